// File: rtl/lsu.sv
// Load/store unit: one request at a time, one data-memory bus transaction,
// extended load result or store ack returned as a single-cycle pulse.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] resp_rdata_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        wen_q, wen_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        bad;
  logic        tmo;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        in_req;

  always_comb begin
    bad = 1'b0;
    unique case (req_size_i)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr_i[0];
      2'b10:   bad = |req_addr_i[1:0];
      default: bad = 1'b1;
    endcase
  end

  assign off     = addr_q[1:0];
  assign ld_byte = mem_rdata_i[{off, 3'b000} +: 8];
  assign ld_half = mem_rdata_i[{off[1], 4'b0000} +: 16];
  assign cnt_inc = cnt_q + 1'b1;
  assign tmo     = (cnt_inc == TO_LIM);

  always_comb begin
    ld_val = mem_rdata_i;
    unique case (size_q)
      2'b00:   ld_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_val = mem_rdata_i;
    endcase
  end

  // Narrow stores are replicated across lanes; the mask picks the live lanes.
  always_comb begin
    st_wdata = wdata_q;
    st_wmask = 4'b1111;
    unique case (size_q)
      2'b00: begin
        st_wdata = {4{wdata_q[7:0]}};
        st_wmask = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{wdata_q[15:0]}};
        st_wmask = 4'b0011 << off;
      end
      default: begin
        st_wdata = wdata_q;
        st_wmask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          wen_d   = req_wen_i;
          uns_d   = req_unsigned_i;
          size_d  = req_size_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = bad;
          state_d = bad ? RESP : REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (tmo) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (mem_req_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A response arriving on the deadline cycle still completes normally.
        if (mem_resp_valid_i) begin
          err_d   = 1'b0;
          rdata_d = wen_q ? 32'd0 : ld_val;
          state_d = RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_req          = (state_q == REQ);
  assign resp_valid_o    = (state_q == RESP);
  assign resp_err_o      = err_q;
  assign resp_rdata_o    = rdata_q;
  assign mem_req_valid_o = in_req;
  assign mem_wen_o       = in_req & wen_q;
  assign mem_addr_o      = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata_o     = (in_req & wen_q) ? st_wdata : 32'd0;
  assign mem_wmask_o     = (in_req & wen_q) ? st_wmask : 4'd0;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: a bus responder with chosen delays and a
// lane/extension reference model computed from byte arithmetic.
module tb_lsu;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid_i      (req_valid),
    .req_wen_i        (req_wen),
    .req_size_i       (req_size),
    .req_unsigned_i   (req_unsigned),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_err_o       (resp_err),
    .resp_rdata_o     (resp_rdata),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_wen_o        (mem_wen),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_wmask_o      (mem_wmask),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_rdata_i      (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size,
      input logic uns, input logic [31:0] addr, input logic [31:0] word);
    int nb;
    logic [31:0] v, m;
    nb = nbytes(size);
    if (nb == 4) return word;
    v = word >> (8 * addr[1:0]);
    m = (32'd1 << (8 * nb)) - 32'd1;
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size,
      input logic [31:0] wd);
    logic [31:0] r;
    int src;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      src = (size == 2'd0) ? 0 : (size == 2'd1) ? (i % 2) : i;
      r[8*i +: 8] = wd[8*src +: 8];
    end
    return r;
  endfunction

  function automatic logic [3:0] model_wmask(input logic [1:0] size,
      input logic [31:0] addr);
    logic [3:0] r;
    int lo, nb;
    lo = int'(addr[1:0]);
    nb = nbytes(size);
    r  = '0;
    for (int i = 0; i < 4; i++)
      r[i] = (i >= lo) && (i < lo + nb);
    return r;
  endfunction

  function automatic logic is_bad(input logic [1:0] size,
                                  input logic [31:0] addr);
    int nb;
    if (size == 2'd3) return 1'b1;
    nb = nbytes(size);
    return (addr % nb) != 0;
  endfunction

  // mode 0: normal bus, 1: ready never comes, 2: response never comes
  task automatic run_txn(input string tag, input logic wen,
      input logic [1:0] size, input logic uns, input logic [31:0] addr,
      input logic [31:0] wd, input logic [31:0] word,
      input int dr, input int rr, input int mode);
    logic bad, tmo;
    logic [31:0] exp_rd;
    int exp_lat, exp_reqs, got_lat, reqs, wcnt;
    logic hs;
    bad      = is_bad(size, addr);
    tmo      = !bad && (mode != 0 || dr + rr + 2 > TO);
    exp_lat  = bad ? 1 : tmo ? TO + 1 : dr + rr + 3;
    exp_reqs = bad ? 0 : (mode == 1) ? TO : dr + 1;
    exp_rd   = (wen || bad || tmo) ? 32'd0 : model_load(size, uns, addr, word);
    got_lat  = -1;
    reqs     = 0;
    wcnt     = 0;
    hs       = 1'b0;
    req_valid    = 1'b1;
    req_wen      = wen;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    step();
    for (int c = 1; c <= 40; c++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
      req_valid      = 1'($urandom_range(0, 1));
      req_wen        = 1'($urandom_range(0, 1));
      req_size       = 2'($urandom_range(0, 3));
      req_unsigned   = 1'($urandom_range(0, 1));
      req_addr       = $urandom;
      req_wdata      = $urandom;
      if (resp_valid) begin
        got_lat = c;
        check({tag, ".err"}, 32'(resp_err), 32'(bad || tmo));
        check({tag, ".rdata"}, resp_rdata, exp_rd);
        req_valid = 1'b0;
        break;
      end
      if (mem_req_valid) begin
        reqs++;
        check({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, ".wen"}, 32'(mem_wen), 32'(wen));
        check({tag, ".wmask"}, 32'(mem_wmask),
              wen ? 32'(model_wmask(size, addr)) : 32'd0);
        if (wen) check({tag, ".wdata"}, mem_wdata, model_wdata(size, wd));
        if (mode != 1 && reqs == dr + 1) begin
          mem_req_ready = 1'b1;
          hs = 1'b1;
        end
        mem_resp_valid = 1'($urandom_range(0, 1));
      end else if (hs) begin
        wcnt++;
        if (mode != 2 && wcnt == rr + 1) begin
          mem_resp_valid = 1'b1;
          mem_rdata      = word;
        end
      end
      step();
    end
    req_valid      = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    check({tag, ".lat"}, 32'(got_lat), 32'(exp_lat));
    check({tag, ".reqs"}, 32'(reqs), 32'(exp_reqs));
    step();
    check({tag, ".one_pulse"}, 32'({resp_valid, mem_req_valid}), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_wen        = 1'b0;
    req_size       = 2'd0;
    req_unsigned   = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    #2;
    check("rst.ctl", 32'({resp_valid, resp_err, mem_req_valid, mem_wen,
                          mem_wmask}), 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.addr", mem_addr | mem_wdata, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    run_txn("lb",  1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0,
            32'h80FF_1234, 0, 0, 0);
    run_txn("lhu", 1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'd0,
            32'hBEEF_0001, 0, 0, 0);
    run_txn("lh",  1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'd0,
            32'hBEEF_0001, 1, 2, 0);
    run_txn("sb",  1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h1234_56AB,
            32'd0, 3, 0, 0);
    run_txn("lw_mis", 1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'd0,
            32'hDEAD_BEEF, 0, 0, 0);
    run_txn("illegal", 1'b1, 2'd3, 1'b0, 32'h0000_4000, 32'h55,
            32'd0, 0, 0, 0);
    run_txn("edge_ok", 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0,
            32'hCAFE_F00D, 3, 3, 0);
    run_txn("edge_to", 1'b0, 2'd2, 1'b0, 32'h0000_5004, 32'd0,
            32'hCAFE_F00D, 3, 4, 0);
    run_txn("to_rdy", 1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'd0,
            32'h1111_2222, 0, 0, 1);

    for (int k = 0; k < 3; k++) begin
      mem_resp_valid = 1'b1;
      mem_rdata      = $urandom;
      step();
      check("stray", 32'(resp_valid), 32'd0);
    end
    mem_resp_valid = 1'b0;
    run_txn("to_rsp", 1'b1, 2'd1, 1'b0, 32'h0000_6002, 32'h0000_9876,
            32'd0, 1, 0, 2);

    // Reset while the unit waits on the bus.
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h0000_7000;
    step();
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("midrst.ctl", 32'({resp_valid, resp_err, mem_req_valid, mem_wen,
                             mem_wmask}), 32'd0);
    check("midrst.data", resp_rdata | mem_addr | mem_wdata, 32'd0);
    step();
    reset = 1'b0;
    step();
    run_txn("post_rst_lw", 1'b0, 2'd2, 1'b0, 32'h0000_7004, 32'd0,
            32'h0BAD_CAFE, 0, 1, 0);

    for (int t = 0; t < 60; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz,
              1'($urandom_range(0, 1)), a, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 14) == 0) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
